// File: rtl/tx_jesd204b_link_ml_if.sv
// Upstream/downstream bus of the multi-lane JESD204B TX link layer.
// Handshake: an octet group on i_data is transferred on a rising clk edge
// where o_ready and i_vld are both high; i_data is don't-care otherwise.
// o_data/o_k/o_state/o_underflow are registered and valid every cycle.
interface tx_jesd204b_link_ml_if #(
  parameter int L = 2
);
  logic [8*L-1:0] i_data;
  logic           i_vld;
  logic           o_ready;
  logic [8*L-1:0] o_data;
  logic [L-1:0]   o_k;
  logic [1:0]     o_state;
  logic           o_underflow;

  modport master (
    output i_data, i_vld,
    input  o_ready, o_data, o_k, o_state, o_underflow
  );

  modport slave (
    input  i_data, i_vld,
    output o_ready, o_data, o_k, o_state, o_underflow
  );
endinterface

// File: rtl/tx_jesd204b_link_ml.sv
// Multi-lane JESD204B transmit link layer: CGS -> ILAS -> DATA, all lanes in
// lock-step with a local multiframe (LMFC) octet counter.
// Optional feature macro: JESD_CHAR_REPLACE_EN (frame/multiframe-end
// character replacement in DATA). Undefined by default.
// All outputs are registered; the counters describe the octet currently
// presented on o_data, so the next-cycle octet is computed from *_d values.
module tx_jesd204b_link_ml #(
  parameter int         L       = 2,
  parameter int         F       = 2,
  parameter int         K       = 16,
  parameter logic [7:0] DID     = 8'h5A,
  parameter logic [3:0] BID     = 4'h0,
  parameter int         ILAS_MF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sync_n,
  input  logic i_sysref,
  tx_jesd204b_link_ml_if.slave bus
);

  typedef enum logic [1:0] {
    ST_CGS  = 2'd0,
    ST_ILAS = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [9:0] FK_LAST = 10'(F * K - 1);
  localparam logic [3:0] F_LAST  = 4'(F - 1);
  localparam logic [7:0] MC_LAST = 8'(ILAS_MF - 1);
  localparam logic [7:0] L_M1    = 8'(L - 1);
  localparam logic [7:0] F_M1    = 8'(F - 1);
  localparam logic [7:0] K_M1    = 8'(K - 1);

  state_e         state_q, state_d;
  logic [9:0]     oc_q, oc_d;         // LMFC octet counter 0..F*K-1
  logic [3:0]     fo_q, fo_d;         // octet within frame 0..F-1
  logic [7:0]     mc_q, mc_d;         // ILAS multiframe index
  logic [1:0]     lo_cnt_q, lo_cnt_d; // consecutive low SYNC~ samples seen
  logic           ready_q, ready_d;
  logic [8*L-1:0] data_q, data_d;
  logic [L-1:0]   k_q, k_d;
  logic           uf_q, uf_d;

  logic           accept;
  logic           resync;
  logic [8*L-1:0] raw_d;              // DATA octets before any substitution
  logic [8:0]     ilas_w;

`ifdef JESD_CHAR_REPLACE_EN
  logic [8*L-1:0] prev_q, prev_d;     // last octet of previous frame, per lane
  logic           prev_vld_q, prev_vld_d;
`endif

  // ILAS octet {k, data} for one lane at a given LMFC position.
  function automatic logic [8:0] ilas_octet(input logic [7:0] lane,
                                            input logic [9:0] oc,
                                            input logic [7:0] mc);
    logic [8:0] r;
    logic [7:0] chk;
    chk = DID + {4'h0, BID} + lane + L_M1 + F_M1 + K_M1;
    r   = {1'b0, oc[7:0]};
    if (oc == 10'd0) begin
      r = {1'b1, 8'h1C};
    end else if (oc == FK_LAST) begin
      r = {1'b1, 8'h7C};
    end else if (mc == 8'd1) begin
      case (oc)
        10'd1:   r = {1'b1, 8'h9C};
        10'd2:   r = {1'b0, DID};
        10'd3:   r = {1'b0, 4'h0, BID};
        10'd4:   r = {1'b0, lane};
        10'd5:   r = {1'b0, L_M1};
        10'd6:   r = {1'b0, F_M1};
        10'd7:   r = {1'b0, K_M1};
        10'd8, 10'd9, 10'd10, 10'd11,
        10'd12, 10'd13, 10'd14:
                 r = 9'h000;
        10'd15:  r = {1'b0, chk};
        default: r = {1'b0, oc[7:0]};
      endcase
    end
    return r;
  endfunction

  // Next-state, LMFC counters and next-cycle lane octets.
  always_comb begin
    state_d  = state_q;
    mc_d     = mc_q;
    lo_cnt_d = 2'd0;
    data_d   = '0;
    k_d      = '0;
    ilas_w   = '0;
    accept   = ready_q & bus.i_vld;
    raw_d    = accept ? bus.i_data : '0;

    // SYSREF only realigns the LMFC while in CGS.
    if ((state_q == ST_CGS) && i_sysref) begin
      oc_d = 10'd0;
      fo_d = 4'd0;
    end else begin
      oc_d = (oc_q == FK_LAST) ? 10'd0 : oc_q + 10'd1;
      fo_d = (fo_q == F_LAST) ? 4'd0 : fo_q + 4'd1;
    end

    // Four consecutive low SYNC~ samples outside CGS force a resync.
    resync = (state_q != ST_CGS) && !i_sync_n && (lo_cnt_q == 2'd3);
    if ((state_q != ST_CGS) && !i_sync_n && !resync) begin
      lo_cnt_d = lo_cnt_q + 2'd1;
    end

    case (state_q)
      ST_CGS: begin
        mc_d = 8'd0;
        // A simultaneous SYSREF wins: ILAS waits for the realigned boundary.
        if (i_sync_n && !i_sysref && (oc_q == FK_LAST)) begin
          state_d = ST_ILAS;
        end
      end
      ST_ILAS: begin
        if (oc_q == FK_LAST) begin
          if (mc_q == MC_LAST) begin
            state_d = ST_DATA;
          end else begin
            mc_d = mc_q + 8'd1;
          end
        end
      end
      default: ;
    endcase

    if (resync) begin
      state_d = ST_CGS;
      mc_d    = 8'd0;
    end

    ready_d = (state_d == ST_DATA);
    // The first DATA slot follows a cycle with o_ready low, so it is filler,
    // not starvation.
    uf_d = (state_d == ST_DATA) && (state_q == ST_DATA) && !bus.i_vld;

    for (int n = 0; n < L; n++) begin
      case (state_d)
        ST_CGS: begin
          data_d[8*n +: 8] = 8'hBC;
          k_d[n]           = 1'b1;
        end
        ST_ILAS: begin
          ilas_w           = ilas_octet(8'(n), oc_d, mc_d);
          data_d[8*n +: 8] = ilas_w[7:0];
          k_d[n]           = ilas_w[8];
        end
        default: begin
          data_d[8*n +: 8] = raw_d[8*n +: 8];
          k_d[n]           = 1'b0;
        end
      endcase
    end

`ifdef JESD_CHAR_REPLACE_EN
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q && (state_d == ST_DATA);
    if ((state_d == ST_DATA) && (fo_d == F_LAST)) begin
      for (int n = 0; n < L; n++) begin
        if (prev_vld_q && (raw_d[8*n +: 8] == prev_q[8*n +: 8])) begin
          data_d[8*n +: 8] = (oc_d == FK_LAST) ? 8'h7C : 8'hFC;
          k_d[n]           = 1'b1;
        end
      end
      // Compare against original data, never the substituted character.
      prev_d     = raw_d;
      prev_vld_d = 1'b1;
    end
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_CGS;
      oc_q     <= 10'd0;
      fo_q     <= 4'd0;
      mc_q     <= 8'd0;
      lo_cnt_q <= 2'd0;
      ready_q  <= 1'b0;
      data_q   <= {L{8'hBC}};
      k_q      <= {L{1'b1}};
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      oc_q     <= oc_d;
      fo_q     <= fo_d;
      mc_q     <= mc_d;
      lo_cnt_q <= lo_cnt_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
      k_q      <= k_d;
      uf_q     <= uf_d;
    end
  end

`ifdef JESD_CHAR_REPLACE_EN
  // Previous-frame octet history for character replacement.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`endif

  assign bus.o_ready     = ready_q;
  assign bus.o_data      = data_q;
  assign bus.o_k         = k_q;
  assign bus.o_state     = state_q;
  assign bus.o_underflow = uf_q;

endmodule

// File: tb/tb_tx_jesd204b_link_ml.sv
// Directed bench for tx_jesd204b_link_ml (L=2, F=2, K=16, ILAS_MF=4).
// Stimulus tasks push the expected output word for the cycle after each
// input set; a negedge monitor pops and compares whenever an entry is due.
module tb_tx_jesd204b_link_ml;

  localparam int W = 22; // {state[1:0], ready, underflow, k[1:0], data[15:0]}
  localparam logic [W-1:0] EXP_CGS = {2'd0, 1'b0, 1'b0, 2'b11, 16'hBCBC};

  logic clk = 1'b0;
  logic rst;
  logic sync_n;
  logic sysref;
  int   cyc = 0;
  int   oc_base = 0;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  string        exp_tag_q[$];

  logic [15:0] prev_m;
  logic        prev_vld_m;

  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_got;
  int           mon_cyc;
  string        mon_tag;

  tx_jesd204b_link_ml_if #(.L(2)) bus ();

  tx_jesd204b_link_ml #(
    .L(2), .F(2), .K(16), .DID(8'h5A), .BID(4'h0), .ILAS_MF(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_sync_n (sync_n),
    .i_sysref (sysref),
    .bus      (bus)
  );

  // Clock and cycle count.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      mon_exp = exp_q.pop_front();
      mon_cyc = exp_cyc_q.pop_front();
      mon_tag = exp_tag_q.pop_front();
      mon_got = {bus.o_state, bus.o_ready, bus.o_underflow, bus.o_k, bus.o_data};
      checks++;
      if (mon_cyc != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d checked late at %0d", mon_tag, mon_cyc, cyc);
      end else if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL %s cyc=%0d: got state=%0d rdy=%b uf=%b k=%b data=%h, expected state=%0d rdy=%b uf=%b k=%b data=%h",
                 mon_tag, cyc, mon_got[21:20], mon_got[19], mon_got[18], mon_got[17:16], mon_got[15:0],
                 mon_exp[21:20], mon_exp[19], mon_exp[18], mon_exp[17:16], mon_exp[15:0]);
      end
    end
  end

  function automatic int oc_at(input int c);
    return (c - oc_base) % 32;
  endfunction

  // Hand-derived ILAS content for L=2, F=2, K=16, DID=5A, BID=0.
  // Checksums: lane0 5A+00+00+01+01+0F = 6B, lane1 = 6C.
  function automatic logic [W-1:0] exp_ilas(input int oc, input int mc);
    logic [7:0] d0, d1;
    logic       k;
    k = 1'b0;
    d0 = 8'(oc);
    d1 = 8'(oc);
    if (oc == 0) begin
      d0 = 8'h1C; d1 = 8'h1C; k = 1'b1;
    end else if (oc == 31) begin
      d0 = 8'h7C; d1 = 8'h7C; k = 1'b1;
    end else if (mc == 1 && oc == 1) begin
      d0 = 8'h9C; d1 = 8'h9C; k = 1'b1;
    end else if (mc == 1 && oc >= 2 && oc <= 15) begin
      case (oc)
        2:       begin d0 = 8'h5A; d1 = 8'h5A; end
        4:       begin d0 = 8'h00; d1 = 8'h01; end
        5, 6:    begin d0 = 8'h01; d1 = 8'h01; end
        7:       begin d0 = 8'h0F; d1 = 8'h0F; end
        15:      begin d0 = 8'h6B; d1 = 8'h6C; end
        default: begin d0 = 8'h00; d1 = 8'h00; end
      endcase
    end
    return {2'd1, 1'b0, 1'b0, k, k, d1, d0};
  endfunction

  task automatic push(input int c, input logic [W-1:0] v, input string tag);
    exp_q.push_back(v);
    exp_cyc_q.push_back(c);
    exp_tag_q.push_back(tag);
  endtask

  // Expected DATA slot; optional replacement applied to the raw octets.
  task automatic push_data(input int c, input logic v, input logic [15:0] d,
                           input logic uf, input string tag);
    logic [15:0] raw;
    logic [15:0] od;
    logic [1:0]  ok;
    raw = v ? d : 16'h0000;
    od  = raw;
    ok  = 2'b00;
`ifdef JESD_CHAR_REPLACE_EN
    if (oc_at(c) % 2 == 1) begin
      for (int n = 0; n < 2; n++) begin
        if (prev_vld_m && raw[8*n +: 8] == prev_m[8*n +: 8]) begin
          od[8*n +: 8] = (oc_at(c) == 31) ? 8'h7C : 8'hFC;
          ok[n] = 1'b1;
        end
      end
      prev_m = raw;
      prev_vld_m = 1'b1;
    end
`endif
    push(c, {2'd2, 1'b1, uf, ok, od}, tag);
  endtask

  // Driver: apply inputs for one cycle, return at the next negedge.
  task automatic tick(input logic sn, input logic sr, input logic v, input logic [15:0] d);
    sync_n = sn;
    sysref = sr;
    bus.i_vld = v;
    bus.i_data = d;
    @(negedge clk);
  endtask

  task automatic cgs_until_oc(input int target);
    while (oc_at(cyc) != target) begin
      push(cyc + 1, EXP_CGS, "cgs_wait");
      tick(1'b0, 1'b0, 1'b0, 16'h0000);
    end
  endtask

  // SYNC~ high: CGS until the next LMFC boundary, leaving cyc = ILAS start - 1.
  task automatic cgs_to_ilas();
    int s;
    s = cyc + 32 - oc_at(cyc);
    while (cyc + 1 < s) begin
      push(cyc + 1, EXP_CGS, "cgs_exit");
      tick(1'b1, 1'b0, 1'b0, 16'h0000);
    end
  endtask

  task automatic run_ilas(input int n);
    for (int i = 0; i < n; i++) begin
      push(cyc + 1, exp_ilas(oc_at(cyc + 1), i / 32), "ilas");
      tick(1'b1, 1'b0, 1'b0, 16'h0000);
    end
  endtask

  // Last /A/ cycle has o_ready low, so offered data must not be taken.
  task automatic enter_data();
    push_data(cyc + 1, 1'b0, 16'h0000, 1'b0, "data_first");
    tick(1'b1, 1'b0, 1'b1, 16'hFFFF);
  endtask

  initial begin
    logic [15:0] pat [4];
    logic        v;
    pat[0] = 16'hA55A; pat[1] = 16'h00FF; pat[2] = 16'h8001; pat[3] = 16'h7E81;
    prev_m = 16'h0000;
    prev_vld_m = 1'b0;
    rst = 1'b1;
    sync_n = 1'b0;
    sysref = 1'b0;
    bus.i_vld = 1'b0;
    bus.i_data = 16'h0000;

    // Reset state.
    for (int c = 1; c <= 3; c++) push(c, EXP_CGS, "reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    oc_base = cyc;

    // CGS held by SYNC~ low.
    for (int i = 0; i < 100; i++) begin
      push(cyc + 1, EXP_CGS, "cgs_hold");
      tick(1'b0, 1'b0, 1'b0, 16'h0000);
    end

    // Release at oc=5, ILAS on the next boundary, full 128-cycle ILAS.
    cgs_until_oc(5);
    cgs_to_ilas();
    run_ilas(128);
    enter_data();

    // Stream with alternating valid; a SYSREF pulse in DATA is ignored.
    for (int i = 0; i < 16; i++) begin
      v = (i % 2 == 0);
      push_data(cyc + 1, v, 16'h1234, !v, "stream");
      tick(1'b1, (i == 5), v, 16'h1234);
    end
    for (int i = 0; i < 4; i++) begin
      push_data(cyc + 1, 1'b1, pat[i], 1'b0, "pattern");
      tick(1'b1, 1'b0, 1'b1, pat[i]);
    end

    // Three low SYNC~ cycles: no effect.
    for (int i = 0; i < 3; i++) begin
      push_data(cyc + 1, 1'b1, 16'h5678, 1'b0, "sync3");
      tick(1'b0, 1'b0, 1'b1, 16'h5678);
    end
    for (int i = 0; i < 3; i++) begin
      push_data(cyc + 1, 1'b1, 16'h9ABC + 16'(i), 1'b0, "sync3_after");
      tick(1'b1, 1'b0, 1'b1, 16'h9ABC + 16'(i));
    end

    // Four low SYNC~ cycles: back to CGS on the next cycle.
    for (int i = 0; i < 3; i++) begin
      push_data(cyc + 1, 1'b1, 16'h4321, 1'b0, "sync4");
      tick(1'b0, 1'b0, 1'b1, 16'h4321);
    end
    push(cyc + 1, EXP_CGS, "resync");
    tick(1'b0, 1'b0, 1'b1, 16'h4321);
    prev_vld_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(cyc + 1, EXP_CGS, "resync_hold");
      tick(1'b0, 1'b0, 1'b0, 16'h0000);
    end

    // SYSREF coincident with the CGS exit condition: SYSREF wins.
    cgs_until_oc(31);
    push(cyc + 1, EXP_CGS, "sysref_wins");
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    oc_base = cyc;
    while (oc_at(cyc) != 9) begin
      push(cyc + 1, EXP_CGS, "sysref_realign");
      tick(1'b1, 1'b0, 1'b0, 16'h0000);
    end
    // SYSREF at oc=9: ILAS starts 32 cycles after this edge.
    push(cyc + 1, EXP_CGS, "sysref_oc9");
    tick(1'b1, 1'b1, 1'b0, 16'h0000);
    oc_base = cyc;
    cgs_to_ilas();
    run_ilas(40);

    // Reset in the middle of ILAS.
    rst = 1'b1;
    push(cyc + 1, EXP_CGS, "rst_mid");
    tick(1'b1, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    oc_base = cyc;
    prev_vld_m = 1'b0;
    cgs_to_ilas();
    run_ilas(128);
    enter_data();

    // Constant 8'hAA on lane 0, unique counts on lane 1.
    for (int i = 0; i < 40; i++) begin
      push_data(cyc + 1, 1'b1, {8'(i + 1), 8'hAA}, 1'b0, "const_aa");
      tick(1'b1, 1'b0, 1'b1, {8'(i + 1), 8'hAA});
    end

    bus.i_vld = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
      errors += exp_q.size();
      checks += exp_q.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
